// File: rtl/riscv_trace_pkg.sv
// Shared types for the retirement trace path: the merged trace record and
// the per-beat data-memory summary that feeds it.
package riscv_trace_pkg;

    localparam int unsigned TRACE_REC_W = 174;
    localparam logic [3:0]  RMASK_LOAD  = 4'hf;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_data;
    } trace_rec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] data;
    } mem_info_t;

    // Store beats report their strobes and write data, loads a full read mask and read data.
    function automatic mem_info_t beat_info(input logic [31:0] addr, input logic write,
                                            input logic [3:0] wstb, input logic [31:0] wdata,
                                            input logic [31:0] rdata);
        mem_info_t m;
        m.addr  = addr;
        m.rmask = write ? 4'h0 : RMASK_LOAD;
        m.wmask = write ? wstb : 4'h0;
        m.data  = write ? wdata : rdata;
        return m;
    endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// Generic synchronous FIFO; full/empty derive from the occupancy count so the
// pointers may wrap freely. A push into a full FIFO is taken only alongside a pop.
module riscv_trace_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/riscv_retire_trace_buf.sv
// Merges each retired instruction with its data-memory beat into a trace record
// and queues records for a valid/ready consumer, counting any that are dropped.
module riscv_retire_trace_buf
    import riscv_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OVF_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ret_valid,
    input  logic [31:0]              ret_pc,
    input  logic [31:0]              ret_instr,
    input  logic                     ret_trap,
    input  logic [4:0]               ret_rd_addr,
    input  logic [31:0]              ret_rd_wdata,
    input  logic                     m_valid,
    input  logic [31:0]              m_addr,
    input  logic                     m_write,
    input  logic [3:0]               m_wstb,
    input  logic [31:0]              m_wdata,
    input  logic [31:0]              m_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TRACE_REC_W-1:0]   out_rec,
    output logic [$clog2(DEPTH):0]   level,
    output logic [OVF_W-1:0]         ovf_cnt
);
    mem_info_t  beat;
    mem_info_t  lat;
    logic       lat_pend;
    trace_rec_t rec;
    trace_rec_t head_rec;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       drop;

    assign beat      = beat_info(m_addr, m_write, m_wstb, m_wdata, m_rdata);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = ret_valid && fifo_full && !pop;
    assign out_rec   = head_rec;

    // A beat in the retire cycle bypasses the latch; otherwise the last latched beat is used.
    always_comb begin
        rec           = '0;
        rec.pc        = ret_pc;
        rec.instr     = ret_instr;
        rec.trap      = ret_trap;
        rec.rd_addr   = ret_rd_addr;
        rec.rd_wdata  = ret_rd_wdata;
        if (m_valid) begin
            rec.mem_addr  = beat.addr;
            rec.mem_rmask = beat.rmask;
            rec.mem_wmask = beat.wmask;
            rec.mem_data  = beat.data;
        end else if (lat_pend) begin
            rec.mem_addr  = lat.addr;
            rec.mem_rmask = lat.rmask;
            rec.mem_wmask = lat.wmask;
            rec.mem_data  = lat.data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lat      <= '0;
            lat_pend <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (ret_valid) begin
                lat      <= '0;
                lat_pend <= 1'b0;
            end else if (m_valid) begin
                lat      <= beat;
                lat_pend <= 1'b1;
            end
            if (drop && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    riscv_trace_fifo #(
        .T     (trace_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (ret_valid),
        .pop     (pop),
        .wdata   (rec),
        .rdata   (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_riscv_retire_trace_buf.sv
// Directed bench for riscv_retire_trace_buf: mem merge, backpressure, overflow, reset.
module tb_riscv_retire_trace_buf;
    import riscv_trace_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned OVF_W = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              ret_valid;
    logic [31:0]       ret_pc;
    logic [31:0]       ret_instr;
    logic              ret_trap;
    logic [4:0]        ret_rd_addr;
    logic [31:0]       ret_rd_wdata;
    logic              m_valid;
    logic [31:0]       m_addr;
    logic              m_write;
    logic [3:0]        m_wstb;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [173:0]      out_rec;
    logic [3:0]        level;
    logic [OVF_W-1:0]  ovf_cnt;
    trace_rec_t        head;

    int checks = 0;
    int errors = 0;

    assign head = out_rec;

    always #5 clock = ~clock;

    riscv_retire_trace_buf #(
        .DEPTH (DEPTH),
        .OVF_W (OVF_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_instr    (ret_instr),
        .ret_trap     (ret_trap),
        .ret_rd_addr  (ret_rd_addr),
        .ret_rd_wdata (ret_rd_wdata),
        .m_valid      (m_valid),
        .m_addr       (m_addr),
        .m_write      (m_write),
        .m_wstb       (m_wstb),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rec      (out_rec),
        .level        (level),
        .ovf_cnt      (ovf_cnt)
    );

    task automatic check(input string tag, input logic [173:0] obs, input logic [173:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic trace_rec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                      input logic trap, input logic [4:0] rd,
                                      input logic [31:0] wd, input logic [31:0] addr,
                                      input logic [3:0] rm, input logic [3:0] wm,
                                      input logic [31:0] data);
        trace_rec_t r;
        r = '{pc, instr, trap, rd, wd, addr, rm, wm, data};
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_trap = 1'b0;
        ret_rd_addr = '0; ret_rd_wdata = '0;
        m_valid = 1'b0; m_addr = '0; m_write = 1'b0; m_wstb = '0;
        m_wdata = '0; m_rdata = '0;
    endtask

    task automatic set_ret(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] rd, input logic [31:0] wd);
        ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_trap = 1'b0;
        ret_rd_addr = rd; ret_rd_wdata = wd;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [31:0] rdata);
        m_valid = 1'b1; m_addr = addr; m_write = 1'b0; m_wstb = '0;
        m_wdata = 32'hffff_ffff; m_rdata = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        out_ready = 1'b0;
        reset_n   = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst_valid", 174'(out_valid), 174'(0));
        check("rst_level", 174'(level), 174'(0));
        check("rst_ovf", 174'(ovf_cnt), 174'(0));

        // 1: load latched two cycles before retirement
        set_load(32'h8000_1000, 32'hDEAD_BEEF);
        tick();
        idle();
        tick();
        set_ret(32'h8000_0010, 32'h0000_a283, 5'd5, 32'hDEAD_BEEF);
        check("t1_no_bypass", 174'(out_valid), 174'(0));
        tick();
        idle();
        check("t1_valid", 174'(out_valid), 174'(1));
        check("t1_rec", out_rec, 174'(mk(32'h8000_0010, 32'h0000_a283, 1'b0, 5'd5, 32'hDEAD_BEEF,
                                          32'h8000_1000, 4'hf, 4'h0, 32'hDEAD_BEEF)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_level", 174'(level), 174'(0));

        // 2: store in the retire cycle, then a retire with no memory access
        set_ret(32'h0000_0014, 32'h0000_0013, 5'd0, 32'h0);
        m_valid = 1'b1; m_addr = 32'h0000_2000; m_write = 1'b1; m_wstb = 4'b0011;
        m_wdata = 32'h0000_1234; m_rdata = 32'h5555_5555;
        tick();
        idle();
        set_ret(32'h0000_0018, 32'h0000_0013, 5'd0, 32'h0);
        tick();
        idle();
        check("t2_level", 174'(level), 174'(2));
        check("t2_store", out_rec, 174'(mk(32'h14, 32'h13, 1'b0, 5'd0, 32'h0,
                                           32'h2000, 4'h0, 4'b0011, 32'h1234)));
        out_ready = 1'b1;
        tick();
        check("t2_nomem", out_rec, 174'(mk(32'h18, 32'h13, 1'b0, 5'd0, 32'h0,
                                           32'h0, 4'h0, 4'h0, 32'h0)));
        tick();
        out_ready = 1'b0;
        check("t2_empty", 174'(out_valid), 174'(0));

        // 3: fill under backpressure, then overflow
        for (int i = 0; i < 8; i++) begin
            set_ret(32'h100 + 32'(4 * i), 32'h13, 5'd0, 32'h0);
            tick();
        end
        idle();
        check("t3_full", 174'(level), 174'(8));
        check("t3_ovf0", 174'(ovf_cnt), 174'(0));
        for (int i = 0; i < 3; i++) begin
            set_ret(32'h180 + 32'(4 * i), 32'h13, 5'd0, 32'h0);
            tick();
        end
        idle();
        check("t3_ovf3", 174'(ovf_cnt), 174'(3));
        check("t3_level", 174'(level), 174'(8));
        check("t3_head", 174'(head.pc), 174'(32'h100));

        // 4: full with simultaneous push and pop
        set_ret(32'h200, 32'h13, 5'd0, 32'h0);
        out_ready = 1'b1;
        tick();
        idle();
        out_ready = 1'b0;
        check("t4_level", 174'(level), 174'(8));
        check("t4_ovf", 174'(ovf_cnt), 174'(3));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_valid", 174'(out_valid), 174'(1));
            check("t4_drain_pc", 174'(head.pc), (i < 7) ? 174'(32'h104 + 32'(4 * i)) : 174'(32'h200));
            tick();
        end
        out_ready = 1'b0;
        check("t4_drained", 174'(level), 174'(0));

        // 5: reset with queued records and a pending load
        for (int i = 0; i < 5; i++) begin
            set_ret(32'h300 + 32'(4 * i), 32'h13, 5'd0, 32'h0);
            tick();
        end
        idle();
        set_load(32'h0000_0300, 32'h0000_0055);
        tick();
        idle();
        check("t5_pre_level", 174'(level), 174'(5));
        reset_n = 1'b0;
        set_ret(32'h3f0, 32'h13, 5'd0, 32'h0);
        tick();
        idle();
        reset_n = 1'b1;
        check("t5_valid", 174'(out_valid), 174'(0));
        check("t5_level", 174'(level), 174'(0));
        check("t5_ovf", 174'(ovf_cnt), 174'(0));
        set_ret(32'h400, 32'h13, 5'd1, 32'h7);
        tick();
        idle();
        check("t5_rec", out_rec, 174'(mk(32'h400, 32'h13, 1'b0, 5'd1, 32'h7,
                                         32'h0, 4'h0, 4'h0, 32'h0)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6: two loads before one retire, last one wins
        set_load(32'h10, 32'h1);
        tick();
        set_load(32'h20, 32'h2);
        tick();
        idle();
        set_ret(32'h500, 32'h13, 5'd2, 32'h2);
        tick();
        idle();
        check("t6_rec", out_rec, 174'(mk(32'h500, 32'h13, 1'b0, 5'd2, 32'h2,
                                         32'h20, 4'hf, 4'h0, 32'h2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
